hazard_scoreboard_unit: RTL and testbench

//  Parametrised hazard controller for the pipelined RV32I core, with depth-generic forwarding, load-use stall and redirect flush.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 11 +
 rtl/hazard_scoreboard_unit_sb_match_prio.sv | 33 +++
 rtl/hazard_scoreboard_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants for the hazard scoreboard and the EX operand muxes that decode its selects.
package hazard_scoreboard_unit_pkg;

  // Operand source codes: 0 = register file, 1..DEPTH = scoreboard slot, DEPTH+1 = retired-write hold.
  localparam int FWD_SEL_RF = 0;

  function automatic int fwd_sel_hold(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_sb_match_prio.sv
// Priority match of one source register against the in-flight slots; the youngest (lowest index) writer wins.
module sb_match_prio
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 3,
  parameter int IDX_W   = 3
) (
  input  logic [RADDR_W-1:0]       rs,
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0]         reg_wr,
  input  logic [DEPTH-1:0]         is_load,
  input  logic [DEPTH*RADDR_W-1:0] rd,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx,
  output logic                     hit_load
);

  always_comb begin
    hit      = 1'b0;
    idx      = IDX_W'(FWD_SEL_RF);
    hit_load = 1'b0;
    // Scan oldest to youngest so the youngest match is the last one written.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs != '0 && valid[k] && reg_wr[k] && rd[k*RADDR_W +: RADDR_W] == rs) begin
        hit      = 1'b1;
        idx      = IDX_W'(k + 1);
        hit_load = is_load[k];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller: in-flight scoreboard, load-use stall, redirect flush, operand forwarding selects
// and saturating performance counters.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int RADDR_W    = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 3,
  parameter int KILL_DEPTH = 1,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid_i,
  input  logic [RADDR_W-1:0]           id_rs1_i,
  input  logic [RADDR_W-1:0]           id_rs2_i,
  input  logic                         id_rs1_used_i,
  input  logic                         id_rs2_used_i,
  input  logic [RADDR_W-1:0]           id_rd_i,
  input  logic                         id_reg_wr_i,
  input  logic                         id_mem_rd_i,
  input  logic                         redirect_i,
  output logic                         pc_wr_en_o,
  output logic                         if_id_wr_en_o,
  output logic                         if_id_flush_o,
  output logic                         id_ex_bubble_o,
  output logic [$clog2(DEPTH+2)-1:0]   fwd_a_sel_o,
  output logic [$clog2(DEPTH+2)-1:0]   fwd_b_sel_o,
  output logic [CNT_W-1:0]             stall_cnt_o,
  output logic [CNT_W-1:0]             flush_cnt_o,
  output logic [CNT_W-1:0]             issue_cnt_o
);

  localparam int SEL_W = $clog2(DEPTH + 2);
  localparam logic [DEPTH-1:0] KILL_BITS = DEPTH'((1 << KILL_DEPTH) - 1);

  // Bit/field 0 is slot 1 (EX), bit/field DEPTH-1 is slot DEPTH (WB).
  logic [DEPTH-1:0]         s_valid;
  logic [DEPTH-1:0]         s_wr;
  logic [DEPTH-1:0]         s_load;
  logic [DEPTH*RADDR_W-1:0] s_rd;
  logic [RADDR_W-1:0]       ex_rs1;
  logic [RADDR_W-1:0]       ex_rs2;
  logic                     hold_valid;
  logic [RADDR_W-1:0]       hold_rd;

  logic                     id1_hit, id2_hit, id1_load, id2_load;
  logic [SEL_W-1:0]         id1_idx, id2_idx;
  logic                     ex1_hit, ex2_hit, ex1_load, ex2_load;
  logic [SEL_W-1:0]         ex1_idx, ex2_idx;
  logic [DEPTH-1:0]         ex_valid;
  logic                     use1, use2, stall, issue;
  logic [DEPTH-1:0]         kill_mask;

  sb_match_prio #(.RADDR_W(RADDR_W), .DEPTH(DEPTH), .IDX_W(SEL_W)) u_id_rs1 (
    .rs(id_rs1_i), .valid(s_valid), .reg_wr(s_wr), .is_load(s_load), .rd(s_rd),
    .hit(id1_hit), .idx(id1_idx), .hit_load(id1_load)
  );

  sb_match_prio #(.RADDR_W(RADDR_W), .DEPTH(DEPTH), .IDX_W(SEL_W)) u_id_rs2 (
    .rs(id_rs2_i), .valid(s_valid), .reg_wr(s_wr), .is_load(s_load), .rd(s_rd),
    .hit(id2_hit), .idx(id2_idx), .hit_load(id2_load)
  );

  // EX operands never forward from their own slot, so slot 1 is hidden from these matchers.
  assign ex_valid = {s_valid[DEPTH-1:1], 1'b0};

  sb_match_prio #(.RADDR_W(RADDR_W), .DEPTH(DEPTH), .IDX_W(SEL_W)) u_ex_rs1 (
    .rs(ex_rs1), .valid(ex_valid), .reg_wr(s_wr), .is_load(s_load), .rd(s_rd),
    .hit(ex1_hit), .idx(ex1_idx), .hit_load(ex1_load)
  );

  sb_match_prio #(.RADDR_W(RADDR_W), .DEPTH(DEPTH), .IDX_W(SEL_W)) u_ex_rs2 (
    .rs(ex_rs2), .valid(ex_valid), .reg_wr(s_wr), .is_load(s_load), .rd(s_rd),
    .hit(ex2_hit), .idx(ex2_idx), .hit_load(ex2_load)
  );

  // A load only stalls its consumer while the result is still too young to be forwarded.
  assign use1  = id_rs1_used_i & id1_hit & id1_load & ((int'(id1_idx) + 1) < LOAD_READY);
  assign use2  = id_rs2_used_i & id2_hit & id2_load & ((int'(id2_idx) + 1) < LOAD_READY);
  assign stall = id_valid_i & ~redirect_i & (use1 | use2);
  assign issue = id_valid_i & ~stall & ~redirect_i;

  assign pc_wr_en_o     = ~stall;
  assign if_id_wr_en_o  = ~stall;
  assign if_id_flush_o  = redirect_i;
  assign id_ex_bubble_o = stall | redirect_i;

  assign kill_mask = redirect_i ? KILL_BITS : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid    <= '0;
      s_wr       <= '0;
      s_load     <= '0;
      s_rd       <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
    end else begin
      s_valid    <= {s_valid[DEPTH-2:0], issue} & ~kill_mask;
      s_wr       <= {s_wr[DEPTH-2:0], id_reg_wr_i};
      s_load     <= {s_load[DEPTH-2:0], id_mem_rd_i};
      s_rd       <= {s_rd[(DEPTH-1)*RADDR_W-1:0], id_rd_i};
      ex_rs1     <= id_rs1_i;
      ex_rs2     <= id_rs2_i;
      // The register file does not write through, so the retiring write stays visible one more cycle.
      hold_valid <= s_valid[DEPTH-1] & s_wr[DEPTH-1];
      hold_rd    <= s_rd[DEPTH*RADDR_W-1 -: RADDR_W];
    end
  end

  always_comb begin
    fwd_a_sel_o = SEL_W'(FWD_SEL_RF);
    fwd_b_sel_o = SEL_W'(FWD_SEL_RF);
    if (s_valid[0]) begin
      if (ex1_hit) begin
        fwd_a_sel_o = ex1_idx;
      end else if (hold_valid && ex_rs1 != '0 && hold_rd == ex_rs1) begin
        fwd_a_sel_o = SEL_W'(fwd_sel_hold(DEPTH));
      end
      if (ex2_hit) begin
        fwd_b_sel_o = ex2_idx;
      end else if (hold_valid && ex_rs2 != '0 && hold_rd == ex_rs2) begin
        fwd_b_sel_o = SEL_W'(fwd_sel_hold(DEPTH));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      issue_cnt_o <= '0;
    end else begin
      if (stall && stall_cnt_o != {CNT_W{1'b1}}) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect_i && flush_cnt_o != {CNT_W{1'b1}}) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      if (issue && issue_cnt_o != {CNT_W{1'b1}}) issue_cnt_o <= issue_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed vector table, random traffic against an
// in-flight-history model, counter saturation on a 4-bit instance, and async reset mid-stall.
module tb_hazard_scoreboard_unit;

  localparam int RADDR_W    = 5;
  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 3;
  localparam int KILL_DEPTH = 1;
  localparam int SEL_W      = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_mem_rd, redirect;
  logic [RADDR_W-1:0] id_rs1, id_rs2, id_rd;

  logic pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble;
  logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt, issue_cnt;

  logic s_pc_wr_en, s_if_id_wr_en, s_if_id_flush, s_id_ex_bubble;
  logic [SEL_W-1:0] s_fwd_a_sel, s_fwd_b_sel;
  logic [3:0] s_stall_cnt, s_flush_cnt, s_issue_cnt;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .id_rd_i(id_rd),
    .id_reg_wr_i(id_reg_wr), .id_mem_rd_i(id_mem_rd), .redirect_i(redirect),
    .pc_wr_en_o(pc_wr_en), .if_id_wr_en_o(if_id_wr_en), .if_id_flush_o(if_id_flush),
    .id_ex_bubble_o(id_ex_bubble), .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .issue_cnt_o(issue_cnt)
  );

  hazard_scoreboard_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .id_rd_i(id_rd),
    .id_reg_wr_i(id_reg_wr), .id_mem_rd_i(id_mem_rd), .redirect_i(redirect),
    .pc_wr_en_o(s_pc_wr_en), .if_id_wr_en_o(s_if_id_wr_en), .if_id_flush_o(s_if_id_flush),
    .id_ex_bubble_o(s_id_ex_bubble), .fwd_a_sel_o(s_fwd_a_sel), .fwd_b_sel_o(s_fwd_b_sel),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .issue_cnt_o(s_issue_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
    int rs1;
    int rs2;
  } ins_t;

  // hist[k-1] is the instruction now in slot k; hist[DEPTH] is what left slot DEPTH last edge.
  ins_t   hist[$];
  longint m_stall, m_flush, m_issue;

  function automatic ins_t empty_ins();
    ins_t e;
    e.v = 0; e.rd = 0; e.wr = 0; e.ld = 0; e.rs1 = 0; e.rs2 = 0;
    return e;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i <= DEPTH; i++) hist.push_back(empty_ins());
    m_stall = 0; m_flush = 0; m_issue = 0;
  endfunction

  function automatic int youngest(int rs, int from_k);
    for (int k = from_k; k <= DEPTH; k++)
      if (rs != 0 && hist[k-1].v && hist[k-1].wr && hist[k-1].rd == rs) return k;
    return 0;
  endfunction

  function automatic bit model_stall();
    int k;
    bit s;
    s = 0;
    if (!id_valid || redirect) return 0;
    if (id_rs1_used) begin
      k = youngest(int'(id_rs1), 1);
      if (k != 0 && hist[k-1].ld && k + 1 < LOAD_READY) s = 1;
    end
    if (id_rs2_used) begin
      k = youngest(int'(id_rs2), 1);
      if (k != 0 && hist[k-1].ld && k + 1 < LOAD_READY) s = 1;
    end
    return s;
  endfunction

  function automatic int model_fwd(int rs);
    int k;
    if (!hist[0].v) return 0;
    k = youngest(rs, 2);
    if (k != 0) return k;
    if (rs != 0 && hist[DEPTH].v && hist[DEPTH].wr && hist[DEPTH].rd == rs) return DEPTH + 1;
    return 0;
  endfunction

  function automatic void model_edge();
    bit   st, iss;
    ins_t n;
    st  = model_stall();
    iss = id_valid && !st && !redirect;
    if (st) m_stall++;
    if (redirect) m_flush++;
    if (iss) m_issue++;
    n = empty_ins();
    if (iss) begin
      n.v = 1; n.rd = int'(id_rd); n.wr = id_reg_wr; n.ld = id_mem_rd;
      n.rs1 = int'(id_rs1); n.rs2 = int'(id_rs2);
    end
    hist.push_front(n);
    void'(hist.pop_back());
    if (redirect) for (int j = 0; j < KILL_DEPTH && j < DEPTH; j++) hist[j].v = 0;
  endfunction

  function automatic longint sat4(longint x);
    return (x > 15) ? 15 : x;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit wr; bit ld; bit redir;
    bit e_pc; bit e_flush; bit e_bub; int e_fa; int e_fb;
  } tvec_t;

  function automatic tvec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit wr, bit ld,
                               bit redir, bit e_pc, bit e_flush, bit e_bub, int e_fa, int e_fb);
    tvec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd; t.wr = wr; t.ld = ld;
    t.redir = redir; t.e_pc = e_pc; t.e_flush = e_flush; t.e_bub = e_bub; t.e_fa = e_fa; t.e_fb = e_fb;
    return t;
  endfunction

  tvec_t tab[18];
  tvec_t no_tab;

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit redir);
    id_valid = v; id_rs1 = RADDR_W'(rs1); id_rs2 = RADDR_W'(rs2);
    id_rs1_used = u1; id_rs2_used = u2; id_rd = RADDR_W'(rd);
    id_reg_wr = wr; id_mem_rd = ld; redirect = redir;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs are already applied; check at the falling edge, then advance the model at the rising edge.
  task automatic run_cycle(input bit use_tab, input tvec_t tv, input int idx);
    bit st;
    logic [9:0] e;
    @(negedge clk);
    st = model_stall();
    exp_q.push_back({~st, ~st, redirect, st | redirect,
                     SEL_W'(model_fwd(int'(dut.ex_rs1))) , SEL_W'(0)});
    e = exp_q.pop_front();
    chk("pc_wr_en", pc_wr_en, e[9]);
    chk("if_id_wr_en", if_id_wr_en, e[8]);
    chk("if_id_flush", if_id_flush, e[7]);
    chk("id_ex_bubble", id_ex_bubble, e[6]);
    chk("fwd_a_sel", fwd_a_sel, model_fwd(hist[0].rs1));
    chk("fwd_b_sel", fwd_b_sel, model_fwd(hist[0].rs2));
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("issue_cnt", issue_cnt, m_issue);
    chk("small_pc_wr_en", s_pc_wr_en, e[9]);
    chk("small_stall_cnt", s_stall_cnt, sat4(m_stall));
    chk("small_flush_cnt", s_flush_cnt, sat4(m_flush));
    chk("small_issue_cnt", s_issue_cnt, sat4(m_issue));
    if (use_tab) begin
      chk($sformatf("vec%0d pc_wr_en", idx), pc_wr_en, tv.e_pc);
      chk($sformatf("vec%0d flush", idx), if_id_flush, tv.e_flush);
      chk($sformatf("vec%0d bubble", idx), id_ex_bubble, tv.e_bub);
      chk($sformatf("vec%0d fwd_a", idx), fwd_a_sel, tv.e_fa);
      chk($sformatf("vec%0d fwd_b", idx), fwd_b_sel, tv.e_fb);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    no_tab = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    //            v rs1 rs2 u1 u2 rd wr ld rdr  pc fl bub fa fb
    tab[0]  = mk(1, 1,  2, 1, 1, 5, 1, 0, 0,   1, 0, 0,  0, 0);  // add x5
    tab[1]  = mk(1, 5,  3, 1, 1, 6, 1, 0, 0,   1, 0, 0,  0, 0);  // sub x6,x5
    tab[2]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  2, 0);  // sub in EX forwards from slot 2
    tab[3]  = mk(1, 6,  0, 1, 0, 8, 1, 1, 0,   1, 0, 0,  0, 0);  // lw x8
    tab[4]  = mk(1, 8,  0, 1, 1, 7, 1, 0, 0,   0, 0, 1,  3, 0);  // add x7,x8: load-use stall
    tab[5]  = mk(1, 8,  0, 1, 1, 7, 1, 0, 0,   1, 0, 0,  0, 0);  // add re-presented, issues
    tab[6]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  3, 0);  // add in EX takes load from slot 3
    tab[7]  = mk(1, 1,  1, 1, 1, 9, 1, 0, 0,   1, 0, 0,  0, 0);  // producer x9
    tab[8]  = mk(1, 2,  3, 1, 1, 10, 1, 0, 0,  1, 0, 0,  0, 0);
    tab[9]  = mk(1, 2,  3, 1, 1, 11, 1, 0, 0,  1, 0, 0,  0, 0);
    tab[10] = mk(1, 9, 10, 1, 1, 12, 1, 0, 0,  1, 0, 0,  0, 0);  // consumer x9,x10
    tab[11] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  4, 3);  // x9 from hold, x10 from slot 3
    tab[12] = mk(1, 0,  0, 1, 0, 13, 1, 1, 0,  1, 0, 0,  0, 0);  // lw x13
    tab[13] = mk(1, 13, 0, 1, 0, 14, 1, 0, 1,  1, 1, 1,  0, 0);  // load-use + redirect together
    tab[14] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  0, 0);
    tab[15] = mk(1, 1,  2, 1, 1, 0, 1, 1, 0,   1, 0, 0,  0, 0);  // lw x0
    tab[16] = mk(1, 0,  0, 1, 1, 1, 1, 0, 0,   1, 0, 0,  0, 0);  // x0 reader: no stall
    tab[17] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  0, 0);  // x0 reader in EX: sel 0

    idle();
    model_reset();
    #2;
    chk("reset pc_wr_en", pc_wr_en, 1);
    chk("reset if_id_wr_en", if_id_wr_en, 1);
    chk("reset bubble", id_ex_bubble, 0);
    chk("reset flush", if_id_flush, 0);
    chk("reset fwd_a", fwd_a_sel, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset issue_cnt", issue_cnt, 0);
    reset_dut();

    for (int i = 0; i < 18; i++) begin
      drive(tab[i].v, tab[i].rs1, tab[i].rs2, tab[i].u1, tab[i].u2, tab[i].rd, tab[i].wr,
            tab[i].ld, tab[i].redir);
      run_cycle(1, tab[i], i);
    end
    idle();
    chk("table stall_cnt", stall_cnt, 1);
    chk("table flush_cnt", flush_cnt, 1);
    chk("table issue_cnt", issue_cnt, 11);

    // Random traffic over a small register range so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      bit ld;
      ld = ($urandom % 3) == 0;
      drive(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom % 2, $urandom % 2, $urandom_range(0, 7), ld | (($urandom % 5) != 0),
            ld, ($urandom % 8) == 0);
      run_cycle(0, no_tab, n);
    end

    // Twenty load-use pairs: the 4-bit stall counter must stick at 15.
    reset_dut();
    for (int n = 0; n < 20; n++) begin
      drive(1, 1, 0, 1, 0, 5, 1, 1, 0);
      run_cycle(0, no_tab, n);
      drive(1, 5, 0, 1, 0, 7, 1, 0, 0);
      run_cycle(0, no_tab, n);
      run_cycle(0, no_tab, n);
    end
    idle();
    run_cycle(0, no_tab, 0);
    chk("sat small stall_cnt", s_stall_cnt, 15);
    chk("sat wide stall_cnt", stall_cnt, 20);

    // Async reset while a load-use stall is being presented.
    reset_dut();
    drive(1, 1, 0, 1, 0, 5, 1, 1, 0);   // lw x5
    run_cycle(0, no_tab, 0);
    drive(1, 5, 0, 1, 0, 6, 1, 1, 0);   // lw x6,0(x5): stalls once
    run_cycle(0, no_tab, 0);
    run_cycle(0, no_tab, 0);
    drive(1, 6, 0, 1, 0, 7, 1, 0, 0);   // add x7,x6: stalling now
    @(negedge clk);
    chk("pre-reset pc_wr_en", pc_wr_en, 0);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midreset pc_wr_en", pc_wr_en, 1);
    chk("midreset if_id_wr_en", if_id_wr_en, 1);
    chk("midreset bubble", id_ex_bubble, 0);
    chk("midreset fwd_a", fwd_a_sel, 0);
    chk("midreset fwd_b", fwd_b_sel, 0);
    chk("midreset stall_cnt", stall_cnt, 0);
    chk("midreset issue_cnt", issue_cnt, 0);
    chk("midreset flush_cnt", flush_cnt, 0);
    idle();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    drive(1, 1, 2, 1, 1, 8, 1, 0, 0);
    run_cycle(0, no_tab, 0);
    chk("post-reset issue_cnt", issue_cnt, 1);
    idle();
    run_cycle(0, no_tab, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
